// File: rtl/gf_pkg.sv
// GF(2^SYMB_WIDTH) helpers and RS(N_LEN, K_LEN) code constants shared by the
// encoder. The generator polynomial is evaluated at elaboration time.
package gf_pkg;

  localparam int SYMB_WIDTH = 8;
  localparam int POLY       = 285;
  localparam int N_LEN      = 255;
  localparam int K_LEN      = 239;
  localparam int ROOTS_NUM  = N_LEN - K_LEN;
  localparam int FIRST_ROOT = 1;
  localparam int CNT_WIDTH  = $clog2(N_LEN);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0] gen_poly_t;
  typedef enum logic {ST_DATA, ST_PARITY} enc_state_t;

  // Shift-and-add multiply, reducing by the primitive polynomial each step.
  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYMB_WIDTH-1] ? ((x << 1) ^ symb_t'(POLY)) : (x << 1);
    end
    return p;
  endfunction

  function automatic symb_t alpha_to_symb(input int e);
    symb_t s;
    s = symb_t'(1);
    for (int i = 0; i < (e % N_LEN); i++) s = gf_mult(s, symb_t'(2));
    return s;
  endfunction

  // g(x) = prod (x - alpha^(FIRST_ROOT+i)); the monic x^ROOTS_NUM term is dropped.
  function automatic gen_poly_t gen_gen_poly();
    logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] g;
    symb_t root;
    gen_poly_t res;
    g    = '0;
    g[0] = symb_t'(1);
    for (int i = 0; i < ROOTS_NUM; i++) begin
      root = alpha_to_symb(FIRST_ROOT + i);
      for (int k = ROOTS_NUM; k > 0; k--) g[k] = g[k-1] ^ gf_mult(g[k], root);
      g[0] = gf_mult(g[0], root);
    end
    for (int k = 0; k < ROOTS_NUM; k++) res[k] = g[k];
    return res;
  endfunction

  localparam gen_poly_t GEN_POLY = gen_gen_poly();

endpackage

// File: rtl/gf_const_mult.sv
// Combinational multiply of a symbol by a fixed field constant.
module gf_const_mult
  import gf_pkg::*;
#(
  parameter logic [SYMB_WIDTH-1:0] COEF = '0
) (
  input  logic [SYMB_WIDTH-1:0] a,
  output logic [SYMB_WIDTH-1:0] y
);

  always_comb y = gf_mult(a, COEF);

endmodule

// File: rtl/rs_enc.sv
// Systematic RS encoder: message symbols pass straight through, then the
// LFSR remainder is shifted out, one symbol per clock with valid/ready on both sides.
module rs_enc
  import gf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SYMB_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYMB_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam logic [CNT_WIDTH-1:0] LAST_DATA = CNT_WIDTH'(K_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_PAR  = CNT_WIDTH'(ROOTS_NUM - 1);

  enc_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
  gen_poly_t            par_q, par_d;
  gen_poly_t            fb_prod;
  symb_t                fb;
  logic                 out_valid_q, out_valid_d;
  symb_t                out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 adv;
  logic                 accept;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_DATA) && adv && !rst;
  assign accept   = in_valid && in_ready;

  // Feedback is forced to zero off-accept so idle/X input never reaches par.
  assign fb = accept ? (in_data ^ par_q[ROOTS_NUM-1]) : '0;

  for (genvar j = 0; j < ROOTS_NUM; j++) begin : g_mult
    gf_const_mult #(.COEF(GEN_POLY[j])) u_mult (
      .a (fb),
      .y (fb_prod[j])
    );
  end

  always_comb begin
    state_d     = state_q;
    data_cnt_d  = data_cnt_q;
    par_cnt_d   = par_cnt_q;
    par_d       = par_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          par_d[0]    = fb_prod[0];
          for (int j = 1; j < ROOTS_NUM; j++) par_d[j] = par_q[j-1] ^ fb_prod[j];
          if (data_cnt_q == LAST_DATA) begin
            data_cnt_d = '0;
            state_d    = ST_PARITY;
          end else begin
            data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
          end
        end else if (adv) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      ST_PARITY: begin
        if (adv) begin
          out_data_d  = par_q[ROOTS_NUM-1];
          out_valid_d = 1'b1;
          out_last_d  = (par_cnt_q == LAST_PAR);
          par_d       = {par_q[ROOTS_NUM-2:0], symb_t'(0)};
          if (par_cnt_q == LAST_PAR) begin
            par_cnt_d = '0;
            state_d   = ST_DATA;
          end else begin
            par_cnt_d = par_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DATA;
      data_cnt_q  <= '0;
      par_cnt_q   <= '0;
      par_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_cnt_q  <= data_cnt_d;
      par_cnt_q   <= par_cnt_d;
      par_q       <= par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
